// File: rtl/fifo_word_packer.sv
// Pops 16-bit words from a synchronous FIFO and packs each pair into one 32-bit word on a
// valid/ready stream; flush emits a held half-word once the FIFO runs dry.
module fifo_word_packer #(
  parameter int unsigned DATA_W    = 16,
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                empty,
  input  logic [DATA_W-1:0]   read_data,
  output logic                rd_en0,
  input  logic                flush,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_partial,
  output logic [CNT_W-1:0]    out_count,
  output logic                busy
);

  typedef enum logic [2:0] {
    StLoReq,
    StLoCap,
    StHiReq,
    StHiCap,
    StOut
  } state_e;

  state_e                state_q;
  logic [DATA_W-1:0]     half_q;
  logic [2*DATA_W-1:0]   out_data_q;
  logic                  out_valid_q;
  logic                  out_partial_q;
  logic [CNT_W-1:0]      out_count_q;

  logic [2*DATA_W-1:0]   full_word;
  logic [2*DATA_W-1:0]   part_word;

  // First popped word sits in the low half when LSB_FIRST, else in the high half.
  always_comb begin
    full_word = '0;
    part_word = '0;
    if (LSB_FIRST) begin
      full_word = {read_data, half_q};
      part_word = {{DATA_W{1'b0}}, half_q};
    end else begin
      full_word = {half_q, read_data};
      part_word = {half_q, {DATA_W{1'b0}}};
    end
  end

  // Reset gates the pop strobe so no word is requested while the FIFO is also held in reset.
  assign rd_en0 = reset & ~empty & ((state_q == StLoReq) | (state_q == StHiReq));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StLoReq;
      half_q        <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_partial_q <= 1'b0;
      out_count_q   <= '0;
    end else begin
      unique case (state_q)
        StLoReq: begin
          if (!empty) begin
            state_q <= StLoCap;
          end
        end
        StLoCap: begin
          half_q  <= read_data;
          state_q <= StHiReq;
        end
        StHiReq: begin
          if (!empty) begin
            state_q <= StHiCap;
          end else if (flush) begin
            out_data_q    <= part_word;
            out_valid_q   <= 1'b1;
            out_partial_q <= 1'b1;
            state_q       <= StOut;
          end
        end
        StHiCap: begin
          out_data_q    <= full_word;
          out_valid_q   <= 1'b1;
          out_partial_q <= 1'b0;
          state_q       <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q   <= 1'b0;
            out_partial_q <= 1'b0;
            out_count_q   <= out_count_q + CNT_W'(1);
            state_q       <= StLoReq;
          end
        end
        default: state_q <= StLoReq;
      endcase
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_partial = out_partial_q;
  assign out_count   = out_count_q;
  assign busy        = (state_q != StLoReq);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench: expected words are derived from the written word stream (pairs in FIFO
// order, flush closes an odd tail) and popped by a monitor on every output handshake.
module tb_fifo_word_packer;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          out_ready;
  int            rdy_mode;

  // Instance A (LSB_FIRST=1) with its FIFO model
  logic          empty_a;
  logic [DW-1:0] read_data_a;
  logic          rd_en0_a;
  logic [2*DW-1:0] out_data_a;
  logic          out_valid_a;
  logic          out_partial_a;
  logic [CW-1:0] out_count_a;
  logic          busy_a;
  logic          wr_en_a;
  logic [DW-1:0] wr_data_a;
  logic [DW-1:0] fq_a[$];
  int            pops_a;

  // Instance B (LSB_FIRST=0) with its FIFO model
  logic          empty_b;
  logic [DW-1:0] read_data_b;
  logic          rd_en0_b;
  logic [2*DW-1:0] out_data_b;
  logic          out_valid_b;
  logic          out_partial_b;
  logic [CW-1:0] out_count_b;
  logic          busy_b;
  logic          wr_en_b;
  logic [DW-1:0] wr_data_b;
  logic [DW-1:0] fq_b[$];

  // Reference model state
  logic [2*DW-1:0] exp_data_q[$];
  logic            exp_part_q[$];
  bit              pending;
  logic [DW-1:0]   pending_word;
  int              model_count;

  int n_checks;
  int n_fail;

  fifo_word_packer #(.DATA_W(DW), .LSB_FIRST(1'b1), .CNT_W(CW)) u_dut_a (
    .clk         (clk),
    .reset       (reset),
    .empty       (empty_a),
    .read_data   (read_data_a),
    .rd_en0      (rd_en0_a),
    .flush       (flush),
    .out_data    (out_data_a),
    .out_valid   (out_valid_a),
    .out_ready   (out_ready),
    .out_partial (out_partial_a),
    .out_count   (out_count_a),
    .busy        (busy_a)
  );

  fifo_word_packer #(.DATA_W(DW), .LSB_FIRST(1'b0), .CNT_W(CW)) u_dut_b (
    .clk         (clk),
    .reset       (reset),
    .empty       (empty_b),
    .read_data   (read_data_b),
    .rd_en0      (rd_en0_b),
    .flush       (1'b0),
    .out_data    (out_data_b),
    .out_valid   (out_valid_b),
    .out_ready   (1'b1),
    .out_partial (out_partial_b),
    .out_count   (out_count_b),
    .busy        (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synch_fifo: read data registered the cycle after the pop, shared reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fq_a.delete();
      empty_a     <= 1'b1;
      read_data_a <= '0;
      pops_a      = 0;
    end else begin
      if (rd_en0_a) begin
        pops_a++;
        if (fq_a.size() > 0) read_data_a <= fq_a.pop_front();
      end
      if (wr_en_a) fq_a.push_back(wr_data_a);
      empty_a <= (fq_a.size() == 0);
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fq_b.delete();
      empty_b     <= 1'b1;
      read_data_b <= '0;
    end else begin
      if (rd_en0_b && fq_b.size() > 0) read_data_b <= fq_b.pop_front();
      if (wr_en_b) fq_b.push_back(wr_data_b);
      empty_b <= (fq_b.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (rdy_mode == 2) out_ready = 1'($urandom % 2);
    else out_ready = (rdy_mode == 1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: samples just before each rising edge.
  initial begin
    logic            prev_valid;
    logic            prev_ready;
    logic [2*DW-1:0] prev_data;
    logic            prev_part;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = '0;
    prev_part  = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (!reset) begin
        prev_valid = 1'b0;
      end else begin
        if (rd_en0_a) check("no_pop_when_empty", 64'(empty_a), 64'd0);
        if (prev_valid && !prev_ready) begin
          check("hold_valid", 64'(out_valid_a), 64'd1);
          check("hold_data", 64'(out_data_a), 64'(prev_data));
          check("hold_partial", 64'(out_partial_a), 64'(prev_part));
        end
        if (out_valid_a) check("no_pop_in_out", 64'(rd_en0_a), 64'd0);
        if (out_valid_a && out_ready) begin
          check("count_before", 64'(out_count_a), 64'(CW'(model_count)));
          if (exp_data_q.size() == 0) begin
            check("unexpected_output", 64'(out_data_a), 64'hDEAD_0000_0000);
          end else begin
            check("out_data", 64'(out_data_a), 64'(exp_data_q.pop_front()));
            check("out_partial", 64'(out_partial_a), 64'(exp_part_q.pop_front()));
          end
          model_count++;
        end
        prev_valid = out_valid_a;
        prev_ready = out_ready;
        prev_data  = out_data_a;
        prev_part  = out_partial_a;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    exp_data_q.delete();
    exp_part_q.delete();
    pending     = 1'b0;
    model_count = 0;
    idle(2);
    reset = 1'b1;
    idle(1);
  endtask

  // Word enters FIFO A; the model pairs it with any held word in arrival order.
  task automatic write_a(input logic [DW-1:0] w);
    wr_en_a   = 1'b1;
    wr_data_a = w;
    if (pending) begin
      exp_data_q.push_back({w, pending_word});
      exp_part_q.push_back(1'b0);
      pending = 1'b0;
    end else begin
      pending      = 1'b1;
      pending_word = w;
    end
    @(negedge clk);
    wr_en_a = 1'b0;
  endtask

  task automatic write_b(input logic [DW-1:0] w);
    wr_en_b   = 1'b1;
    wr_data_b = w;
    @(negedge clk);
    wr_en_b = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    if (pending) begin
      exp_data_q.push_back({{DW{1'b0}}, pending_word});
      exp_part_q.push_back(1'b1);
      pending = 1'b0;
    end
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string name, input bit need_idle);
    int k;
    k = 0;
    while (k < 2000 && !(exp_data_q.size() == 0 && fq_a.size() == 0 && empty_a &&
                         (!need_idle || !busy_a))) begin
      @(negedge clk);
      k++;
    end
    idle(2);
    check(name, 64'(k < 2000), 64'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    rdy_mode  = 1;
    wr_en_a   = 1'b0;
    wr_data_a = '0;
    wr_en_b   = 1'b0;
    wr_data_b = '0;
    pending   = 1'b0;
    model_count = 0;
    pending_word = '0;
    #1;
    check("rst_rd_en0", 64'(rd_en0_a), 64'd0);
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_out_data", 64'(out_data_a), 64'd0);
    check("rst_out_count", 64'(out_count_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    do_reset();

    // Basic pair
    write_a(16'h1111);
    write_a(16'h2222);
    wait_drain("drain_pair", 1'b1);
    check("pair_pops", 64'(pops_a), 64'd2);
    check("pair_count", 64'(out_count_a), 64'd1);

    // Flush of a lone word
    do_reset();
    write_a(16'hAAAA);
    idle(10);
    check("lone_busy", 64'(busy_a), 64'd1);
    pulse_flush();
    wait_drain("drain_flush", 1'b1);
    check("flush_count", 64'(out_count_a), 64'd1);
    check("flush_busy", 64'(busy_a), 64'd0);

    // Backpressure with 8 queued words
    do_reset();
    rdy_mode = 0;
    for (int i = 1; i <= 8; i++) write_a(~DW'(i));
    idle(30);
    check("bp_valid", 64'(out_valid_a), 64'd1);
    check("bp_data", 64'(out_data_a), 64'hFFFD_FFFE);
    check("bp_pops", 64'(pops_a), 64'd2);
    rdy_mode = 1;
    wait_drain("drain_bp", 1'b1);
    check("bp_count", 64'(out_count_a), 64'd4);
    check("bp_pops_total", 64'(pops_a), 64'd8);

    // Flush while idle does nothing; flush with data waiting loses to the pop
    do_reset();
    flush = 1'b1;
    idle(10);
    check("idle_flush_pops", 64'(pops_a), 64'd0);
    check("idle_flush_count", 64'(out_count_a), 64'd0);
    check("idle_flush_valid", 64'(out_valid_a), 64'd0);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) write_a(16'h5000 + 16'(i));
    flush = 1'b1;
    wait_drain("drain_popwins", 1'b1);
    flush = 1'b0;
    check("popwins_count", 64'(out_count_a), 64'd2);

    // Asynchronous reset while holding an output word
    do_reset();
    rdy_mode = 0;
    write_a(16'h1111);
    write_a(16'h2222);
    idle(10);
    check("pre_rst_data", 64'(out_data_a), 64'h2222_1111);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("async_valid", 64'(out_valid_a), 64'd0);
    check("async_data", 64'(out_data_a), 64'd0);
    check("async_count", 64'(out_count_a), 64'd0);
    exp_data_q.delete();
    exp_part_q.delete();
    pending     = 1'b0;
    model_count = 0;
    idle(2);
    reset    = 1'b1;
    rdy_mode = 1;
    idle(1);
    write_a(16'h3333);
    write_a(16'h4444);
    wait_drain("drain_post_rst", 1'b1);
    check("post_rst_count", 64'(out_count_a), 64'd1);

    // Randomized bursts with random backpressure
    do_reset();
    rdy_mode = 2;
    for (int b = 0; b < 30; b++) begin
      int n;
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        write_a(DW'($urandom_range(0, 65535)));
        if ($urandom % 3 == 0) idle(1);
      end
      idle(int'($urandom_range(0, 8)));
    end
    wait_drain("drain_rand", 1'b0);
    if (pending) begin
      idle(5);
      pulse_flush();
    end
    wait_drain("drain_rand_final", 1'b1);
    check("rand_count", 64'(out_count_a), 64'(CW'(model_count)));
    rdy_mode = 1;

    // Upper-half-first ordering
    do_reset();
    write_b(16'h1234);
    write_b(16'h5678);
    k = 0;
    while (k < 50 && !out_valid_b) begin
      @(negedge clk);
      k++;
    end
    check("b_valid_seen", 64'(out_valid_b), 64'd1);
    check("b_data", 64'(out_data_b), 64'h1234_5678);
    check("b_partial", 64'(out_partial_b), 64'd0);

    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
